// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational 32-bit ALU between two valid/ready requesters.
// Latency: accept -> one EXEC cycle -> response held in RESP until resp_ready; 3 cycles min per op.
// Backpressure: new requests get no ready until the response handshake completes and state is IDLE.
module alu_share_arbiter #(
    parameter int DATA_W  = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_aluc,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_aluc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_aluc,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_r,
    output logic [3:0]        resp_flags,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_gnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_aluc;
    logic              r_resp_vld;
    logic              r_resp_id;
    logic [DATA_W-1:0] r_resp_r;
    logic [3:0]        r_resp_flags;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_carry_ok;
    logic w_ovf_ok;

    // On a tie the requester that did not win last time gets the ALU.
    assign w_idle = (r_state == IDLE) && rst_n;
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last_gnt);
    assign w_gnt0 = req0_valid && !w_gnt1;

    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;

    always_comb begin
        w_carry_ok = 1'b0;
        w_ovf_ok   = 1'b0;
        case (r_alu_aluc)
            4'b0000, 4'b0001, 4'b1010, 4'b1100,
            4'b1101, 4'b1110, 4'b1111: w_carry_ok = 1'b1;
            4'b0010, 4'b0011:          w_ovf_ok   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_gnt   <= ~RR_INIT;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_aluc   <= '0;
            r_resp_vld   <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_r     <= '0;
            r_resp_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_alu_a    <= w_gnt1 ? req1_a    : req0_a;
                        r_alu_b    <= w_gnt1 ? req1_b    : req0_b;
                        r_alu_aluc <= w_gnt1 ? req1_aluc : req0_aluc;
                        r_resp_id  <= w_gnt1;
                        r_last_gnt <= w_gnt1;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_resp_r     <= alu_r;
                    r_resp_flags <= {alu_zero, alu_carry & w_carry_ok,
                                     alu_negative, alu_overflow & w_ovf_ok};
                    r_resp_vld   <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_vld <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_resp_vld <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_aluc   = r_alu_aluc;
    assign resp_valid = r_resp_vld;
    assign resp_id    = r_resp_id;
    assign resp_r     = r_resp_r;
    assign resp_flags = r_resp_flags;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU on the alu_* port.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_aluc, req1_aluc;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [31:0] resp_r;
    logic [3:0]  resp_flags;
    logic        force_cv;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(32), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_r(resp_r), .resp_flags(resp_flags), .busy(busy)
    );

    // Reference ALU; force_cv drives carry and overflow high regardless of opcode.
    always_comb begin
        logic [32:0] t;
        t            = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r        = alu_a;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_aluc)
            4'b0000: begin alu_r = t[31:0]; alu_carry = t[32]; end
            4'b0001: begin alu_r = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
            4'b0010: begin
                alu_r = t[31:0];
                alu_carry = t[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
            end
            4'b0011: begin
                alu_r = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
            end
            4'b0100: alu_r = alu_a & alu_b;
            4'b0101: alu_r = alu_a | alu_b;
            4'b0110: alu_r = alu_a ^ alu_b;
            4'b0111: alu_r = ~(alu_a | alu_b);
            default: ;
        endcase
        alu_zero     = (alu_r == 32'd0);
        alu_negative = alu_r[31];
        if (force_cv) begin
            alu_carry    = 1'b1;
            alu_overflow = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents one op, waits (bounded) for its ready, and stops in the cycle the response should appear.
    task automatic issue_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] c, output bit ok);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_aluc = c;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c;
        end
        #1;
        ok = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if ((!id && req0_ready === 1'b1) || (id && req1_ready === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 0; req1_valid = 0; resp_ready = 0; force_cv = 0;
        req0_a = 0; req0_b = 0; req0_aluc = 0; req1_a = 0; req1_b = 0; req1_aluc = 0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
        checks++;
        if (alu_a !== 0 || alu_b !== 0 || alu_aluc !== 0) begin
            errors++; $display("FAIL reset_alu: a=%h b=%h aluc=%h expected 0", alu_a, alu_b, alu_aluc);
        end
        checks++;
        if (resp_r !== 0 || resp_flags !== 0 || resp_id !== 0) begin
            errors++; $display("FAIL reset_resp: r=%h flags=%b id=%b expected 0", resp_r, resp_flags, resp_id);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_aluc = 4'b0000; resp_ready = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        checks++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || alu_a !== 5 || alu_b !== 3) begin
            errors++; $display("FAIL single_exec: busy=%b vld=%b a=%0d b=%0d expected 1 0 5 3",
                               busy, resp_valid, alu_a, alu_b);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_r !== 32'd8 || resp_flags !== 4'b0000) begin
            errors++; $display("FAIL single_resp: vld=%b id=%b r=%0d flags=%b expected 1 0 8 0000",
                               resp_valid, resp_id, resp_r, resp_flags);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: vld=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        bit found;
        int last_acc;
        bit exp;
        rst_n = 0; tick(); rst_n = 1; tick();
        req0_valid = 1; req0_a = 10; req0_b = 1;  req0_aluc = 4'b0000;
        req1_valid = 1; req1_a = 20; req1_b = 5;  req1_aluc = 4'b0001;
        resp_ready = 1;
        #1;
        last_acc = 0;
        for (int op = 0; op < 4; op++) begin
            exp = op[0];
            found = 0;
            for (int w = 0; w < 8; w++) begin
                if (req0_ready === 1'b1 || req1_ready === 1'b1) begin found = 1; break; end
                tick();
            end
            checks++;
            if (!found || req1_ready !== exp || req0_ready !== !exp) begin
                errors++; $display("FAIL rr_grant op%0d: r0=%b r1=%b expected grant %0d",
                                   op, req0_ready, req1_ready, exp);
            end
            if (op > 0) begin
                checks++;
                if (cyc - last_acc !== 3) begin
                    errors++; $display("FAIL rr_spacing op%0d: %0d cycles expected 3", op, cyc - last_acc);
                end
            end
            last_acc = cyc;
            tick(); tick();
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== exp || resp_r !== (exp ? 32'd15 : 32'd11)) begin
                errors++; $display("FAIL rr_resp op%0d: vld=%b id=%b r=%0d expected 1 %0d %0d",
                                   op, resp_valid, resp_id, resp_r, exp, exp ? 15 : 11);
            end
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();
    endtask

    task automatic test_overflow();
        bit ok;
        resp_ready = 1;
        issue_op(1'b1, 32'h7FFF_FFFF, 32'd1, 4'b0010, ok);
        checks++;
        if (!ok || resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_r !== 32'h8000_0000 || resp_flags !== 4'b0011) begin
            errors++; $display("FAIL ovf_add: ok=%b vld=%b id=%b r=%h flags=%b expected 1 1 1 80000000 0011",
                               ok, resp_valid, resp_id, resp_r, resp_flags);
        end
        tick();
    endtask

    task automatic test_flag_mask();
        bit ok;
        resp_ready = 1;
        force_cv = 1;
        issue_op(1'b0, 32'd0, 32'd0, 4'b0100, ok);
        checks++;
        if (!ok || resp_r !== 0 || resp_flags !== 4'b1000) begin
            errors++; $display("FAIL mask_and: ok=%b r=%h flags=%b expected 1 0 1000", ok, resp_r, resp_flags);
        end
        tick();
        issue_op(1'b0, 32'd0, 32'd0, 4'b0000, ok);
        checks++;
        if (!ok || resp_flags !== 4'b1100) begin
            errors++; $display("FAIL mask_addu: ok=%b flags=%b expected 1 1100", ok, resp_flags);
        end
        tick();
        issue_op(1'b0, 32'd0, 32'd0, 4'b0011, ok);
        checks++;
        if (!ok || resp_flags !== 4'b1001) begin
            errors++; $display("FAIL mask_sub: ok=%b flags=%b expected 1 1001", ok, resp_flags);
        end
        tick();
        force_cv = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        resp_ready = 0;
        issue_op(1'b0, 32'd7, 32'd9, 4'b0000, ok);
        req1_valid = 1; req1_a = 1; req1_b = 2; req1_aluc = 4'b0000;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (!ok || req1_ready !== 1'b0 || resp_valid !== 1'b1 || resp_r !== 32'd16 ||
                resp_id !== 1'b0 || alu_a !== 7 || alu_b !== 9) begin
                errors++; $display("FAIL bp_hold cyc%0d: r1rdy=%b vld=%b r=%0d id=%b a=%0d b=%0d expected 0 1 16 0 7 9",
                                   k, req1_ready, resp_valid, resp_r, resp_id, alu_a, alu_b);
            end
            tick();
        end
        resp_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin
            errors++; $display("FAIL bp_handshake_rdy: r1rdy=%b expected 0", req1_ready);
        end
        tick();
        checks++;
        if (req1_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_regrant: r1rdy=%b busy=%b vld=%b expected 1 0 0",
                               req1_ready, busy, resp_valid);
        end
        tick();
        req1_valid = 0;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_r !== 32'd3) begin
            errors++; $display("FAIL bp_second: vld=%b id=%b r=%0d expected 1 1 3", resp_valid, resp_id, resp_r);
        end
        tick();
    endtask

    task automatic test_reset_exec();
        bit seen;
        resp_ready = 1;
        req0_valid = 1; req0_a = 32'h55; req0_b = 32'h1; req0_aluc = 4'b0000;
        #1;
        tick();
        req0_valid = 0;
        rst_n = 0;
        tick();
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || alu_a !== 0) begin
            errors++; $display("FAIL rst_exec: busy=%b vld=%b a=%h expected 0 0 0", busy, resp_valid, alu_a);
        end
        rst_n = 1;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (resp_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_dropped: resp_valid=1 expected 0 after dropped op");
        end
        req0_valid = 1; req0_a = 2; req0_b = 2; req0_aluc = 4'b0000;
        req1_valid = 1; req1_a = 9; req1_b = 9; req1_aluc = 4'b0000;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_first_grant: r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_r !== 32'd4) begin
            errors++; $display("FAIL rst_first_resp: vld=%b id=%b r=%0d expected 1 0 4", resp_valid, resp_id, resp_r);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_flag_mask();
        test_backpressure();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
